// File: rtl/line_fetch_sched.sv
// line_fetch_sched: during h-blank, fetches the next display line as fixed-size read bursts.
// Latency: the trigger is sampled on cycle T and the first request is valid on cycle T+1.
// Backpressure: req_addr holds while req_ready is low; at most MAX_OUTST bursts are left uncompleted.
module line_fetch_sched #(
  parameter int WIDTH     = 12,
  parameter int H_ACT     = 1280,
  parameter int V_ACT     = 720,
  parameter int V_TOT     = 750,
  parameter int BURST_LEN = 64,
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 24,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_pix,
  input  logic              rst_pix,
  input  logic              en,
  input  logic [WIDTH-1:0]  sx,
  input  logic [WIDTH-1:0]  sy,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        req_len,
  input  logic              rd_done,
  output logic [WIDTH-1:0]  fetch_line,
  output logic              line_ready,
  output logic              underrun,
  output logic              underrun_sticky,
  input  logic              clr_underrun
);

  localparam int NB = H_ACT / BURST_LEN;
  localparam int CW = $clog2(NB + 1);

  localparam logic [WIDTH-1:0]  SX_TRIG     = WIDTH'(H_ACT);
  localparam logic [WIDTH-1:0]  SY_ACT      = WIDTH'(V_ACT);
  localparam logic [WIDTH-1:0]  SY_LAST_ACT = WIDTH'(V_ACT - 1);
  localparam logic [WIDTH-1:0]  SY_LAST     = WIDTH'(V_TOT - 1);
  localparam logic [CW-1:0]     NB_LAST     = CW'(NB - 1);
  localparam logic [ADDR_W-1:0] BASE_C      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LINE_STEP   = ADDR_W'(H_ACT);
  localparam logic [ADDR_W-1:0] BURST_STEP  = ADDR_W'(BURST_LEN);
  localparam logic [31:0]       MAX_OUTST_U = 32'(MAX_OUTST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     issued, done;
  logic [ADDR_W-1:0] line_base, addr_acc, new_base;
  logic [WIDTH-1:0]  target;
  logic [31:0]       outst;
  logic              armed;
  logic              trig_hit, accept, busy_trig, hs, done_inc;
  logic              last_issue, last_done, disp_bad;

  // The line after the last active one has no successor; the last blanking line wraps to line 0.
  assign trig_hit  = en && (sx == SX_TRIG) && ((sy < SY_LAST_ACT) || (sy == SY_LAST));
  assign target    = (sy == SY_LAST) ? '0 : sy + WIDTH'(1);
  assign new_base  = (target == '0) ? BASE_C : line_base + LINE_STEP;
  assign accept    = trig_hit && (state == IDLE);
  assign busy_trig = trig_hit && (state != IDLE);

  assign outst      = 32'(issued - done);
  assign hs         = req_valid && req_ready;
  // A completion with nothing outstanding cannot belong to this line.
  assign done_inc   = (state != IDLE) && rd_done && (done != issued);
  assign last_issue = hs && (issued == NB_LAST);
  assign last_done  = (state == DRAIN) && done_inc && (done == NB_LAST);
  assign disp_bad   = armed && (sx == '0) && (sy < SY_ACT) && !(line_ready && (fetch_line == sy));

  assign req_addr = addr_acc;
  assign req_len  = 8'(BURST_LEN);

  // State register.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: issue all bursts of the line, then wait for the last completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requests are offered only while the outstanding window has room.
  always_comb begin
    req_valid = 1'b0;
    if (state == ISSUE) req_valid = (outst < MAX_OUTST_U);
  end

  // Line bookkeeping; the burst address advances by accumulation on each handshake.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      issued     <= '0;
      done       <= '0;
      line_base  <= BASE_C;
      addr_acc   <= '0;
      fetch_line <= '0;
      line_ready <= 1'b0;
      armed      <= 1'b0;
    end else if (accept) begin
      issued     <= '0;
      done       <= '0;
      line_base  <= new_base;
      addr_acc   <= new_base;
      fetch_line <= target;
      line_ready <= 1'b0;
      armed      <= 1'b1;
    end else begin
      if (hs) begin
        issued   <= issued + CW'(1);
        addr_acc <= addr_acc + BURST_STEP;
      end
      if (done_inc)  done       <= done + CW'(1);
      if (last_done) line_ready <= 1'b1;
      if (!en)       armed      <= 1'b0;
    end
  end

  // Underrun: a busy fetcher at trigger time, or an unfinished line at display start; set beats clear.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      underrun        <= 1'b0;
      underrun_sticky <= 1'b0;
    end else begin
      underrun <= busy_trig || disp_bad;
      if (busy_trig || disp_bad) underrun_sticky <= 1'b1;
      else if (clr_underrun)     underrun_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_fetch_sched.sv
// Bench for line_fetch_sched: a free-running timing generator, a rd_done responder,
// and a scoreboard monitor that matches request addresses and underrun pulses against queues.
module tb_line_fetch_sched;

  localparam int WIDTH     = 12;
  localparam int H_ACT     = 64;
  localparam int BURST_LEN = 16;
  localparam int V_ACT     = 4;
  localparam int V_TOT     = 6;
  localparam int MAX_OUTST = 2;
  localparam int ADDR_W    = 24;
  localparam int BASE_ADDR = 'h100;
  localparam int H_TOT     = 80;

  logic              clk = 1'b0;
  logic              rst, en, req_ready, clr;
  logic              rd_done = 1'b0;
  logic [WIDTH-1:0]  sx = '0;
  logic [WIDTH-1:0]  sy = WIDTH'(V_TOT - 1);
  logic              req_valid, line_ready, underrun, underrun_sticky;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic [WIDTH-1:0]  fetch_line;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic tg_run = 1'b0;
  logic withhold = 1'b0;
  int man_req = 0;
  int man_served = 0;
  int done_rd = 0;
  int addr_rd = 0;
  int ur_rd = 0;
  int acc_cnt = 0;
  int dn_cnt = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  int                exp_ur[$];
  int                done_q[$];

  line_fetch_sched #(
    .WIDTH(WIDTH), .H_ACT(H_ACT), .V_ACT(V_ACT), .V_TOT(V_TOT),
    .BURST_LEN(BURST_LEN), .MAX_OUTST(MAX_OUTST), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk_pix(clk), .rst_pix(rst), .en(en), .sx(sx), .sy(sy),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rd_done(rd_done), .fetch_line(fetch_line), .line_ready(line_ready),
    .underrun(underrun), .underrun_sticky(underrun_sticky), .clr_underrun(clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Timing generator and completion responder, both updated just after the edge.
  always @(posedge clk) begin
    #1;
    if (tg_run) begin
      if (sx == WIDTH'(H_TOT - 1)) begin
        sx = '0;
        sy = (sy == WIDTH'(V_TOT - 1)) ? '0 : sy + WIDTH'(1);
      end else begin
        sx = sx + WIDTH'(1);
      end
    end
    rd_done = 1'b0;
    if (done_rd < done_q.size() && done_q[done_rd] == cyc + 1) begin
      rd_done = 1'b1;
      done_rd++;
    end else if (man_req > man_served) begin
      rd_done = 1'b1;
      man_served++;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pos(input int x, input int y, input string name);
    int k;
    k = 0;
    step();
    while (!(sx == WIDTH'(x) && sy == WIDTH'(y)) && k < 2000) begin
      step();
      k++;
    end
    if (!(sx == WIDTH'(x) && sy == WIDTH'(y))) begin
      tests++;
      fails++;
      $display("FAIL wait_%s: position (%0d,%0d) not reached, required within 2000 cycles", name, x, y);
    end
  endtask

  task automatic push_line(input int first);
    for (int i = 0; i < H_ACT / BURST_LEN; i++)
      exp_addr.push_back(ADDR_W'(first + i * BURST_LEN));
  endtask

  // Scoreboard: every handshake and every underrun pulse is matched against the expected queues.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_cnt = 0;
        dn_cnt  = 0;
      end else begin
        if (req_valid && req_ready) begin
          chk("outstanding_limit", 32'((acc_cnt - dn_cnt) < MAX_OUTST), 32'd1);
          chk("req_len", 32'(req_len), 32'(BURST_LEN));
          if (addr_rd < exp_addr.size()) begin
            chk("req_addr", 32'(req_addr), 32'(exp_addr[addr_rd]));
            addr_rd++;
          end else begin
            tests++;
            fails++;
            $display("FAIL unexpected_request: addr 0x%0h at cycle %0d, required none", req_addr, cyc);
          end
          acc_cnt++;
          if (!withhold) done_q.push_back(cyc + 4);
        end
        if (rd_done && dn_cnt < acc_cnt) dn_cnt++;
        if (underrun) begin
          if (ur_rd < exp_ur.size()) begin
            chk("underrun_cycle", 32'(cyc), 32'(exp_ur[ur_rd]));
            ur_rd++;
          end else begin
            tests++;
            fails++;
            $display("FAIL unexpected_underrun: pulse at cycle %0d, required none", cyc);
          end
        end
      end
    end
  endtask

  task automatic scenario();
    rst = 1'b1; en = 1'b0; req_ready = 1'b0; clr = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_req_addr", 32'(req_addr), 0);
    chk("rst_req_len", 32'(req_len), 16);
    chk("rst_fetch_line", 32'(fetch_line), 0);
    chk("rst_line_ready", 32'(line_ready), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_sticky", 32'(underrun_sticky), 0);
    step();
    rst = 1'b0; en = 1'b1; req_ready = 1'b1;

    // Line 0, triggered on the last blanking line.
    push_line('h100);
    tg_run = 1'b1;
    wait_pos(0, 0, "l0");
    chk("l0_line_ready", 32'(line_ready), 1);
    chk("l0_fetch_line", 32'(fetch_line), 0);

    // Line 1.
    push_line('h140);
    wait_pos(0, 1, "l1");
    chk("l1_line_ready", 32'(line_ready), 1);
    chk("l1_fetch_line", 32'(fetch_line), 1);

    // Line 2 with completions withheld: only two bursts fit in the window.
    withhold = 1'b1;
    exp_addr.push_back(24'h180);
    exp_addr.push_back(24'h190);
    wait_pos(0, 2, "l2");
    exp_ur.push_back(cyc + 1);
    req_ready = 1'b0;
    man_req++;
    step();
    @(negedge clk);
    chk("l2_sticky_set", 32'(underrun_sticky), 1);
    chk("l2_not_ready", 32'(line_ready), 0);

    // Next trigger while still issuing, with a coincident clear.
    wait_pos(64, 2, "busy");
    clr = 1'b1;
    exp_ur.push_back(cyc + 1);
    chk("held_req_valid", 32'(req_valid), 1);
    chk("held_req_addr", 32'(req_addr), 32'h1a0);
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("sticky_set_wins", 32'(underrun_sticky), 1);
    chk("busy_fetch_line", 32'(fetch_line), 2);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", 32'(underrun_sticky), 0);

    // Reset in the middle of the line, then a late completion.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_valid", 32'(req_valid), 0);
    chk("mid_rst_line_ready", 32'(line_ready), 0);
    chk("mid_rst_fetch_line", 32'(fetch_line), 0);
    man_req++;
    repeat (5) step();
    @(negedge clk);
    chk("late_done_req_valid", 32'(req_valid), 0);
    chk("late_done_line_ready", 32'(line_ready), 0);
    chk("late_done_sticky", 32'(underrun_sticky), 0);

    // Line 0 again: the second request stalls 10 cycles, and fetching is disabled mid-line.
    withhold = 1'b0;
    req_ready = 1'b1;
    push_line('h100);
    wait_pos(64, 5, "bp");
    step();
    step();
    req_ready = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_req_valid", 32'(req_valid), 1);
      chk("bp_req_addr", 32'(req_addr), 32'h110);
      step();
    end
    req_ready = 1'b1;
    wait_pos(70, 1, "en_low");
    chk("en_low_line_ready", 32'(line_ready), 1);
    chk("en_low_fetch_line", 32'(fetch_line), 0);
    chk("en_low_sticky", 32'(underrun_sticky), 0);
    chk("all_requests_seen", 32'(addr_rd), 32'(exp_addr.size()));
    chk("all_underruns_seen", 32'(ur_rd), 32'(exp_ur.size()));
  endtask

  initial begin
    fork
      monitor();
      scenario();
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
